// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: default sizes, command
// encodings, flag bit positions and the control FSM state type.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_CMD_LEN = 4;

    // Command encodings; 0000 and 1111 both decode as NOP.
    localparam logic [3:0] CMD_NOP  = 4'b0000;
    localparam logic [3:0] CMD_MOV  = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_ADC  = 4'b0011;
    localparam logic [3:0] CMD_SUB  = 4'b0100;
    localparam logic [3:0] CMD_SBC  = 4'b0101;
    localparam logic [3:0] CMD_AND  = 4'b0110;
    localparam logic [3:0] CMD_ORR  = 4'b0111;
    localparam logic [3:0] CMD_EOR  = 4'b1000;
    localparam logic [3:0] CMD_MVN  = 4'b1001;
    localparam logic [3:0] CMD_CMP  = 4'b1010;
    localparam logic [3:0] CMD_TST  = 4'b1011;
    localparam logic [3:0] CMD_ADDR = 4'b1100;
    localparam logic [3:0] CMD_MUL  = 4'b1101;
    localparam logic [3:0] CMD_MLA  = 4'b1110;
    localparam logic [3:0] CMD_NOP2 = 4'b1111;

    // Bit positions inside the {Z,C,N,V} flag nibble.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    // True for the commands that go through the iterative multiplier.
    function automatic logic is_mul_cmd(input logic [3:0] code);
        return (code == CMD_MUL) || (code == CMD_MLA);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier. A start pulse captures the operands and
// preloads the accumulator (op_c for MLA, zero for MUL); it then performs
// one partial-product step per clock for WIDTH clocks. On the final step
// 'done' is high and 'product' already holds the finished sum, so the
// caller can register it on that same edge.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic             busy_q,   busy_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_step;

    // Partial-product step: add the shifted multiplicand when the current
    // multiplier bit is set; also drives the next-state of all registers.
    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            count_d  = '0;
            acc_d    = use_acc ? op_c : '0;
            mcand_d  = op_a;
            mplier_d = op_b;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (count_q == LAST) begin
                busy_d  = 1'b0;
                count_d = '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Iteration state; an asynchronous reset abandons any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign done    = busy_q && (count_q == LAST);
    assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU with a valid/ready handshake. Single-cycle commands
// are computed combinationally from the live operands and registered on
// the accepting edge; MUL/MLA hand their operands to alu_mul_iter and
// stall the pipeline until it finishes. The result stays held until the
// consumer raises out_ready, and the architectural flag register is
// written on the edge a result is loaded when s_bit accompanied it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int CMD_LEN = ALU_CMD_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CMD_LEN-1:0] cmd,
    input  logic               s_bit,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH-1:0]   op_c,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags_out,
    output logic [3:0]         status
);

    alu_state_e       state_q,  state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q,  flags_d;
    logic [3:0]       status_q, status_d;
    logic             s_bit_q,  s_bit_d;

    logic [3:0]       cmd_code;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [3:0]       mul_flags;

    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             arith_v;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic             flag_write;

    assign cmd_code = cmd[3:0];
    assign is_mul   = is_mul_cmd(cmd_code);
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .use_acc (cmd_code == CMD_MLA),
        .op_a    (op_a),
        .op_b    (op_b),
        .op_c    (op_c),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle datapath: one WIDTH+1 adder shared by all arithmetic
    // commands, where subtraction adds ~b so the carry out is NOT-borrow.
    always_comb begin
        b_eff      = op_b;
        cin        = 1'b0;
        alu_res    = '0;
        alu_flags  = status_q;
        flag_write = 1'b1;
        case (cmd_code)
            CMD_ADC: cin = status_q[FLAG_C];
            CMD_SUB, CMD_CMP: begin
                b_eff = ~op_b;
                cin   = 1'b1;
            end
            CMD_SBC: begin
                b_eff = ~op_b;
                cin   = status_q[FLAG_C];
            end
            default: ;
        endcase
        sum     = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        arith_v = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        case (cmd_code)
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC, CMD_CMP: begin
                alu_res           = sum[WIDTH-1:0];
                alu_flags[FLAG_Z] = (sum[WIDTH-1:0] == '0);
                alu_flags[FLAG_C] = sum[WIDTH];
                alu_flags[FLAG_N] = sum[WIDTH-1];
                alu_flags[FLAG_V] = arith_v;
            end
            CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR, CMD_TST: begin
                case (cmd_code)
                    CMD_MOV:          alu_res = op_b;
                    CMD_MVN:          alu_res = ~op_b;
                    CMD_ORR:          alu_res = op_a | op_b;
                    CMD_EOR:          alu_res = op_a ^ op_b;
                    default:          alu_res = op_a & op_b;
                endcase
                alu_flags[FLAG_Z] = (alu_res == '0);
                alu_flags[FLAG_N] = alu_res[WIDTH-1];
            end
            CMD_ADDR: begin
                alu_res    = sum[WIDTH-1:0];
                flag_write = 1'b0;
            end
            default: begin
                flag_write = 1'b0;
            end
        endcase
    end

    // Multiply flags: N and Z from the product, C and V carried over.
    always_comb begin
        mul_flags         = status_q;
        mul_flags[FLAG_Z] = (mul_product == '0);
        mul_flags[FLAG_N] = mul_product[WIDTH-1];
    end

    // Control FSM: accept from IDLE or straight out of HOLD, run the
    // multiplier in MUL, and hold the result until it is consumed.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        status_d  = status_q;
        s_bit_d   = s_bit_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start = 1'b1;
                        s_bit_d   = s_bit;
                        state_d   = ST_MUL;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        if (s_bit && flag_write) begin
                            status_d = alu_flags;
                        end
                        state_d = ST_HOLD;
                    end
                end else if (state_q == ST_HOLD && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_product;
                    flags_d  = mul_flags;
                    if (s_bit_q) begin
                        status_d = mul_flags;
                    end
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, output and status registers; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            status_q <= '0;
            s_bit_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            status_q <= status_d;
            s_bit_q  <= s_bit_d;
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign result    = result_q;
    assign flags_out = flags_q;
    assign status    = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq with hand-computed expected values.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   cmd;
    logic         s_bit;
    logic [W-1:0] op_a, op_b, op_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags_out;
    logic [3:0]   status;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W), .CMD_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .s_bit     (s_bit),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags_out (flags_out),
        .status    (status)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] c, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] acc);
        in_valid = 1'b1;
        cmd      = c;
        s_bit    = s;
        op_a     = a;
        op_b     = b;
        op_c     = acc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; cmd = 4'h0; s_bit = 1'b0;
        op_a = '0; op_b = '0; op_c = '0; out_ready = 1'b1;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        n_checks++; if (flags_out !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", flags_out); end
        n_checks++; if (status !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_status: got %b expected 0000", status); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_overflow();
        applyStimulus(CMD_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h0);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || result !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL add_ovf_result: got valid=%b result=%h expected valid=1 result=80000000", out_valid, result); end
        n_checks++; if (flags_out !== 4'b0011) begin n_fail++; $display("[TB] FAIL add_ovf_flags: got %b expected 0011", flags_out); end
        n_checks++; if (status !== 4'b0011) begin n_fail++; $display("[TB] FAIL add_ovf_status: got %b expected 0011", status); end
        tick();
    endtask

    task automatic test_sub_sbc();
        applyStimulus(CMD_SUB, 1'b1, 32'd5, 32'd5, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'h0, 4'b1100}) begin n_fail++; $display("[TB] FAIL sub_eq: got %h/%b expected 00000000/1100", result, flags_out); end
        n_checks++; if (status !== 4'b1100) begin n_fail++; $display("[TB] FAIL sub_status: got %b expected 1100", status); end
        applyStimulus(CMD_SBC, 1'b1, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'h0, 4'b1100}) begin n_fail++; $display("[TB] FAIL sbc_c1: got %h/%b expected 00000000/1100", result, flags_out); end
        applyStimulus(CMD_ADD, 1'b1, 32'd1, 32'd1, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'd2, 4'b0000}) begin n_fail++; $display("[TB] FAIL add_small: got %h/%b expected 00000002/0000", result, flags_out); end
        applyStimulus(CMD_SBC, 1'b1, 32'h0, 32'h0, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'hFFFF_FFFF, 4'b0010}) begin n_fail++; $display("[TB] FAIL sbc_c0: got %h/%b expected ffffffff/0010", result, flags_out); end
        n_checks++; if (status !== 4'b0010) begin n_fail++; $display("[TB] FAIL sbc_status: got %b expected 0010", status); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mla();
        logic stall_ok;
        applyStimulus(CMD_ADD, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'h0, 4'b1101}) begin n_fail++; $display("[TB] FAIL add_carry_ovf: got %h/%b expected 00000000/1101", result, flags_out); end
        applyStimulus(CMD_MLA, 1'b1, 32'h0000_FFFF, 32'h0001_0001, 32'd3);
        tick();
        in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; op_c = 32'h5555_5555;
        stall_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) stall_ok = 1'b0;
            if (i != 31) tick();
        end
        n_checks++; if (stall_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL mla_stall: got in_ready/out_valid active during multiply, expected both 0 for 32 cycles"); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || result !== 32'h0000_0002) begin n_fail++; $display("[TB] FAIL mla_result: got valid=%b result=%h expected valid=1 result=00000002", out_valid, result); end
        n_checks++; if (flags_out !== 4'b0101) begin n_fail++; $display("[TB] FAIL mla_flags: got %b expected 0101", flags_out); end
        n_checks++; if (status !== 4'b0101) begin n_fail++; $display("[TB] FAIL mla_status: got %b expected 0101", status); end
        tick();
    endtask

    task automatic test_mul();
        int cycles;
        applyStimulus(CMD_MUL, 1'b0, 32'h8000_0001, 32'd3, 32'h0000_00FF);
        tick();
        in_valid = 1'b0;
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        n_checks++; if (cycles !== 32) begin n_fail++; $display("[TB] FAIL mul_latency: got %0d cycles expected 32", cycles); end
        n_checks++; if ({result, flags_out} !== {32'h8000_0003, 4'b0111}) begin n_fail++; $display("[TB] FAIL mul_result: got %h/%b expected 80000003/0111", result, flags_out); end
        n_checks++; if (status !== 4'b0101) begin n_fail++; $display("[TB] FAIL mul_status_kept: got %b expected 0101", status); end
        tick();
    endtask

    task automatic test_backpressure();
        logic hold_ok;
        out_ready = 1'b0;
        applyStimulus(CMD_ORR, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0);
        tick();
        applyStimulus(CMD_ADD, 1'b0, 32'd2, 32'd3, 32'h0);
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0000_00FF || flags_out !== 4'b0101) hold_ok = 1'b0;
            tick();
        end
        n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold: got result=%h flags=%b in_ready=%b expected stable 000000ff/0101 in_ready=0", result, flags_out, in_ready); end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if ({out_valid, result, flags_out} !== {1'b1, 32'd5, 4'b0000}) begin n_fail++; $display("[TB] FAIL bp_next_accept: got %b/%h/%b expected 1/00000005/0000", out_valid, result, flags_out); end
        n_checks++; if (status !== 4'b0101) begin n_fail++; $display("[TB] FAIL bp_status: got %b expected 0101", status); end
        tick();
    endtask

    task automatic test_status_guard();
        applyStimulus(CMD_ADDR, 1'b1, 32'h0000_1000, 32'h0000_0020, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'h0000_1020, 4'b0101}) begin n_fail++; $display("[TB] FAIL addr_result: got %h/%b expected 00001020/0101", result, flags_out); end
        n_checks++; if (status !== 4'b0101) begin n_fail++; $display("[TB] FAIL addr_status: got %b expected 0101", status); end
        applyStimulus(CMD_MOV, 1'b0, 32'h0000_AAAA, 32'h0, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'h0, 4'b1101}) begin n_fail++; $display("[TB] FAIL mov_result: got %h/%b expected 00000000/1101", result, flags_out); end
        n_checks++; if (status !== 4'b0101) begin n_fail++; $display("[TB] FAIL mov_status: got %b expected 0101", status); end
        applyStimulus(CMD_TST, 1'b1, 32'h0000_00F0, 32'h0000_000F, 32'h0);
        tick();
        n_checks++; if ({result, flags_out} !== {32'h0, 4'b1101}) begin n_fail++; $display("[TB] FAIL tst_result: got %h/%b expected 00000000/1101", result, flags_out); end
        n_checks++; if (status !== 4'b1101) begin n_fail++; $display("[TB] FAIL tst_status: got %b expected 1101", status); end
        applyStimulus(CMD_NOP, 1'b1, 32'd5, 32'd6, 32'h0);
        tick();
        n_checks++; if ({out_valid, result, flags_out} !== {1'b1, 32'h0, 4'b1101}) begin n_fail++; $display("[TB] FAIL nop_result: got %b/%h/%b expected 1/00000000/1101", out_valid, result, flags_out); end
        n_checks++; if (status !== 4'b1101) begin n_fail++; $display("[TB] FAIL nop_status: got %b expected 1101", status); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        applyStimulus(CMD_MUL, 1'b1, 32'd3, 32'd4, 32'h0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("[TB] FAIL rst_mul_handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
        n_checks++; if ({result, flags_out, status} !== {32'h0, 4'b0000, 4'b0000}) begin n_fail++; $display("[TB] FAIL rst_mul_clear: got %h/%b/%b expected 00000000/0000/0000", result, flags_out, status); end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(CMD_ADD, 1'b0, 32'd1, 32'd2, 32'h0);
        tick();
        in_valid = 1'b0;
        n_checks++; if ({out_valid, result, flags_out} !== {1'b1, 32'd3, 4'b0000}) begin n_fail++; $display("[TB] FAIL rst_next_add: got %b/%h/%b expected 1/00000003/0000", out_valid, result, flags_out); end
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_no_stale_mul: got out_valid=%b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_sbc();
        test_mla();
        test_mul();
        test_backpressure();
        test_status_guard();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised execute-stage ALU with a valid/ready handshake, a registered result and a registered status (flags) register. It covers the full data-processing command set, corrects ARM carry semantics for subtraction and adds an iterative multiply (MUL/MLA). It sits between the ID/EX pipeline register and the EX/MEM register. The pipeline stalls on `in_ready` low while a multiply iterates.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 8.
- `CMD_LEN`, 4: command field width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: command/operands valid.
- `in_ready` out 1: block accepts a command this cycle.
- `cmd` in CMD_LEN: execute command (encodings below).
- `s_bit` in 1: update flag register with this command's flags.
- `op_a`, `op_b`, `op_c` in WIDTH each: operands; `op_c` is the accumulator, used by MLA only.
- `out_valid` out 1: `result`/`flags_out` valid.
- `out_ready` in 1: downstream consumes result.
- `result` out WIDTH: registered result.
- `flags_out` out 4: this command's flags `{Z,C,N,V}`.
- `status` out 4: architectural flag register `{Z,C,N,V}`; C feeds ADC/SBC.

## Operation
- Encodings: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, CMP 1010, TST 1011, ADDR 1100 (LDR/STR address), MUL 1101, MLA 1110. 0000 and 1111 are NOP: result 0, flags unchanged, out_valid still produced.
- Arithmetic is in WIDTH+1 bits.
  - ADD: a+b. ADC: a+b+C.
  - SUB/CMP: a+~b+1. SBC: a+~b+C.
  - C = bit WIDTH of the sum, i.e. ARM NOT-borrow.
  - V = (a[msb]==b'[msb]) & (r[msb]!=a[msb]), where b' is the second addend as actually added.
- Logical ops, MOV, MVN, TST: C and V are copied from `status`.
- N = r[WIDTH-1]. Z = (r == 0).
- CMP/TST: `result` carries the computed value; the consumer ignores it.
- ADDR: a+b; flags_out equals `status`; status never updated regardless of `s_bit`.
- MUL: low WIDTH bits of a*b. MLA: low WIDTH bits of a*b + c.
  - N and Z from the result; C and V copied from `status`.
  - Computed by radix-2 shift-add over WIDTH iterations.
- `status` is written with flags_out at the cycle result is loaded, only if `s_bit` was set at acceptance. Architecturally this is CMP/TST always; the decoder asserts `s_bit` for them.
- FSM:
  - IDLE → (accept, single-cycle cmd) → HOLD.
  - IDLE → (accept, MUL/MLA) → MUL.
  - MUL: iteration counter counts 0..WIDTH-1; at WIDTH-1 → HOLD.
  - HOLD → (out_ready) → IDLE, or directly accept next if in_valid (back-to-back).
- `in_ready` = (state==IDLE) | (state==HOLD & out_ready).
- Operands, cmd and s_bit are captured at acceptance; later input changes have no effect.

## Timing
- Reset values:
  - state IDLE; iteration counter 0.
  - out_valid 0, result 0, flags_out 0, status 0, in_ready 1.
- Single-cycle ops: accepted at edge t, out_valid high after edge t; latency 1. Throughput 1/cycle when out_ready stays high.
- MUL/MLA: accepted at edge t, out_valid after edge t+WIDTH; in_ready low for WIDTH cycles.
- Backpressure: while out_valid & !out_ready, result/flags_out/out_valid are stable and in_ready is 0.
- Flags for a command reach `status` on the same edge its result is loaded. A command accepted on that same edge reads the old `status`. The decoder must not issue a C-dependent op back-to-back behind an S-op: the hazard is owned by the hazard unit.
- Asynchronous rst mid-multiply aborts it: no out_valid, status cleared.

## Structure
- Shared package/defines file `alu_pkg`: WIDTH default, command encodings, flag bit positions {Z=3,C=2,N=1,V=0}.
- Sub-module `alu_mul_iter`: shift-add multiplier with start/done, counter and accumulator preload (op_c or 0).
- The top level holds the combinational add/logic datapath, the FSM, the output register and the status register.

## Test plan
- ADD 0x7FFFFFFF+1, s_bit=1 → result 0x80000000, flags_out {Z0,C0,N1,V1}, status updated after 1 cycle.
- SUB 5-5 then SBC 0-0 with status C=1 → first gives Z1,C1; SBC gives 0, C1. With C=0, SBC 0-0 → 0xFFFFFFFF, N1, C0.
- MLA a=0xFFFF, b=0x10001, c=3 → after exactly 32 cycles result 0xFFFFFFFF+3 mod 2^32 = 0x00000002; in_ready low throughout.
- Backpressure: out_ready=0 for 5 cycles after an ORR → result stable, in_ready 0. Raise out_ready with a new in_valid → next command accepted on that edge.
- ADDR with s_bit=1 and MOV with s_bit=0 → status unchanged; TST 0xF0&0x0F with s_bit=1 → Z1, C/V preserved.
- Assert rst at cycle 10 of a MUL → outputs and status 0 immediately. Next ADD accepted the first cycle after rst deasserts.
